// File: rtl/bsg_dfi_clk_gate_pkg.sv
// Shared types for the DFI/AXI clock-gate recovery block: state encoding and width.
package bsg_dfi_clk_gate_pkg;

  localparam int unsigned state_width_lp = 3;

  typedef enum logic [state_width_lp-1:0] {
    IDLE      = 3'd0,
    WAIT_GATE = 3'd1,
    FLUSH     = 3'd2,
    HOLD      = 3'd3,
    RELEASE   = 3'd4
  } state_e;

endpackage

// File: rtl/bsg_dfi_recovery_sat_counter.sv
// Saturating up-counter with synchronous reset, clear and enable; stops at max_p.
module bsg_dfi_recovery_sat_counter #(
  parameter int unsigned      width_p = 8,
  parameter logic [width_p-1:0] max_p = '1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_o <= '0;
    end else if (en_i && (count_o != max_p)) begin
      count_o <= count_o + width_p'(1);
    end
  end

endmodule

// File: rtl/bsg_dfi_clk_gate_recovery.sv
// AXI-side overflow detection and clock-gate recovery sequencer for the DFI/AXI async FIFO.
// Optional manual release (HOLD state) enabled by BSG_DFI_CLK_GATE_RECOVERY_MANUAL_RELEASE_EN.
module bsg_dfi_clk_gate_recovery
  import bsg_dfi_clk_gate_pkg::*;
#(
  parameter int unsigned flush_hold_p   = 4,
  parameter int unsigned gate_timeout_p = 1024,
  parameter int unsigned count_width_p  = 8
) (
  input  logic                     axi_clk_i,
  input  logic                     axi_reset_i,
  input  logic                     fifo_v_i,
  input  logic                     fifo_full_i,
  input  logic                     fifo_empty_i,
  input  logic                     user_clk_gate_i,
  input  logic                     clear_i,
  input  logic                     release_i,
  output logic                     axi_fifo_error_o,
  output logic                     flush_o,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic [count_width_p-1:0] error_count_o
);

  localparam int unsigned timer_width_lp = (gate_timeout_p > 1) ? $clog2(gate_timeout_p) : 1;
  localparam int unsigned empty_width_lp = $clog2(flush_hold_p + 1);
  localparam logic [timer_width_lp-1:0] timer_max_lp  = timer_width_lp'(gate_timeout_p - 1);
  localparam logic [empty_width_lp-1:0] empty_last_lp = empty_width_lp'(flush_hold_p - 1);

  state_e state_q, state_n;
  logic   error_q, flush_q, busy_q, timeout_q, fired_q;
  logic   error_n, flush_n, busy_n, timeout_n, fired_n;
  logic   overflow, timeout_set, flush_done;
  logic [timer_width_lp-1:0] timer;
  logic [empty_width_lp-1:0] empty_cnt;

  assign overflow   = fifo_v_i & fifo_full_i;
  assign flush_done = fifo_empty_i & (empty_cnt == empty_last_lp);
  // One-shot: fires once per WAIT_GATE visit so a later clear_i can drop the flag.
  assign timeout_set = (state_q == WAIT_GATE) & ~user_clk_gate_i
                     & (timer == timer_max_lp) & ~fired_q;

`ifndef BSG_DFI_CLK_GATE_RECOVERY_MANUAL_RELEASE_EN
  logic unused_release;
  assign unused_release = release_i;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:      if (overflow) state_n = WAIT_GATE;
      WAIT_GATE: if (user_clk_gate_i) state_n = FLUSH;
`ifdef BSG_DFI_CLK_GATE_RECOVERY_MANUAL_RELEASE_EN
      FLUSH:     if (flush_done) state_n = HOLD;
      HOLD:      if (release_i) state_n = RELEASE;
`else
      FLUSH:     if (flush_done) state_n = RELEASE;
`endif
      RELEASE:   if (!user_clk_gate_i) state_n = IDLE;
      default:   state_n = IDLE;
    endcase

    error_n   = (state_n == WAIT_GATE) || (state_n == FLUSH) || (state_n == HOLD);
    flush_n   = (state_n == FLUSH);
    busy_n    = (state_n != IDLE);
    fired_n   = (state_q == WAIT_GATE) & (fired_q | timeout_set);
    timeout_n = timeout_set ? 1'b1 : (clear_i ? 1'b0 : timeout_q);
  end

  always_ff @(posedge axi_clk_i) begin
    if (axi_reset_i) begin
      state_q   <= IDLE;
      error_q   <= 1'b0;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      fired_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      error_q   <= error_n;
      flush_q   <= flush_n;
      busy_q    <= busy_n;
      timeout_q <= timeout_n;
      fired_q   <= fired_n;
    end
  end

  bsg_dfi_recovery_sat_counter #(
    .width_p(timer_width_lp),
    .max_p  (timer_max_lp)
  ) timer_cnt (
    .clk_i  (axi_clk_i),
    .reset_i(axi_reset_i),
    .clear_i(state_q != WAIT_GATE),
    .en_i   (~user_clk_gate_i),
    .count_o(timer)
  );

  // Counts consecutive empty cycles while flushing; any non-empty cycle restarts it.
  bsg_dfi_recovery_sat_counter #(
    .width_p(empty_width_lp),
    .max_p  (empty_width_lp'(flush_hold_p))
  ) empty_cnt_inst (
    .clk_i  (axi_clk_i),
    .reset_i(axi_reset_i),
    .clear_i((state_q != FLUSH) | ~fifo_empty_i),
    .en_i   (fifo_empty_i),
    .count_o(empty_cnt)
  );

  bsg_dfi_recovery_sat_counter #(
    .width_p(count_width_p)
  ) error_cnt (
    .clk_i  (axi_clk_i),
    .reset_i(axi_reset_i),
    .clear_i(clear_i),
    .en_i   ((state_q == RELEASE) & ~user_clk_gate_i),
    .count_o(error_count_o)
  );

  assign axi_fifo_error_o = error_q;
  assign flush_o          = flush_q;
  assign busy_o           = busy_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_bsg_dfi_clk_gate_recovery.sv
// Directed bench for bsg_dfi_clk_gate_recovery (flush_hold_p=4, gate_timeout_p=16, count_width_p=2).
`timescale 1ns/1ps
module tb_bsg_dfi_clk_gate_recovery;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_v, fifo_full, fifo_empty, gate, clr, rel;
  logic       err, flush, busy, tmo;
  logic [1:0] cnt;
  int         compared = 0;
  int         mismatched = 0;

  bsg_dfi_clk_gate_recovery #(
    .flush_hold_p  (4),
    .gate_timeout_p(16),
    .count_width_p (2)
  ) dut (
    .axi_clk_i       (clk),
    .axi_reset_i     (rst),
    .fifo_v_i        (fifo_v),
    .fifo_full_i     (fifo_full),
    .fifo_empty_i    (fifo_empty),
    .user_clk_gate_i (gate),
    .clear_i         (clr),
    .release_i       (rel),
    .axi_fifo_error_o(err),
    .flush_o         (flush),
    .busy_o          (busy),
    .timeout_o       (tmo),
    .error_count_o   (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Single overflow in IDLE; afterwards the block sits in WAIT_GATE.
  task automatic trigger(input string tag);
    fifo_v = 1'b1; fifo_full = 1'b1; fifo_empty = 1'b0;
    step();
    fifo_v = 1'b0; fifo_full = 1'b0;
    chk({tag, "_err_on"}, err, 1);
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_noflush_wait"}, flush, 0);
  endtask

  // Entered right after FLUSH has exited (HOLD or RELEASE, gate still 1).
  task automatic release_tail(input string tag, input int hold_n, input int exp_cnt, input logic c);
`ifdef BSG_DFI_CLK_GATE_RECOVERY_MANUAL_RELEASE_EN
    for (int i = 0; i < hold_n; i++) begin
      step();
      chk({tag, "_hold_err"}, err, 1);
      chk({tag, "_hold_flush"}, flush, 0);
    end
    rel = 1'b1;
    step();
    rel = 1'b0;
`endif
    chk({tag, "_rel_err"}, err, 0);
    chk({tag, "_rel_busy"}, busy, 1);
    gate = 1'b0; clr = c;
    step();
    clr = 1'b0;
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_err"}, err, 0);
    chk({tag, "_count"}, cnt, exp_cnt);
  endtask

  // From WAIT_GATE: gate arrives, FIFO reports empty, overflow attempts during FLUSH are ignored.
  task automatic finish_from_wait(input string tag, input int hold_n, input int exp_cnt, input logic c);
    gate = 1'b1;
    step();
    chk({tag, "_flush_on"}, flush, 1);
    chk({tag, "_flush_err"}, err, 1);
    fifo_empty = 1'b1; fifo_v = 1'b1; fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_flush_hold"}, flush, 1);
    end
    step();
    fifo_v = 1'b0; fifo_full = 1'b0;
    chk({tag, "_flush_off"}, flush, 0);
    release_tail(tag, hold_n, exp_cnt, c);
  endtask

  initial begin
    rst = 1'b1; fifo_v = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b0;
    gate = 1'b0; clr = 1'b0; rel = 1'b0;
    step(); step();
    chk("rst_err", err, 0);
    chk("rst_flush", flush, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", tmo, 0);
    chk("rst_count", cnt, 0);
    rst = 1'b0;

    // Enqueues without full never trigger recovery.
    fifo_v = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("t1_err", err, 0);
      chk("t1_busy", busy, 0);
    end
    fifo_v = 1'b0;
    chk("t1_count", cnt, 0);

    // Basic recovery, gate arrives after 5 cycles in WAIT_GATE.
    trigger("t2");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_wait_err", err, 1);
      chk("t2_wait_flush", flush, 0);
    end
    finish_from_wait("t2", 50, 1, 1'b0);

    // Gate never asserts: timeout sixteen cycles after WAIT_GATE entry.
    trigger("t3");
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("t3_no_timeout", tmo, 0);
    end
    step();
    chk("t3_timeout", tmo, 1);
    repeat (5) step();
    chk("t3_sticky", tmo, 1);
    chk("t3_busy", busy, 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t3_cleared", tmo, 0);
    chk("t3_cnt_cleared", cnt, 0);
    chk("t3_still_wait", err, 1);
    finish_from_wait("t3", 3, 1, 1'b0);

    // clear_i on the same edge as the timeout set: set wins.
    trigger("t3b");
    repeat (15) step();
    clr = 1'b1; step(); clr = 1'b0;
    chk("t3b_set_wins", tmo, 1);
    chk("t3b_cnt_cleared", cnt, 0);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t3b_cleared", tmo, 0);
    finish_from_wait("t3b", 3, 1, 1'b0);

    // Empty pattern 1,1,0,1,1,1,1: exit only after the final four 1s.
    trigger("t4");
    gate = 1'b1;
    step();
    chk("t4_flush_on", flush, 1);
    begin
      logic [6:0] pat;
      pat = 7'b1111011;
      for (int i = 0; i < 7; i++) begin
        fifo_empty = pat[i];
        step();
        chk("t4_flush", flush, (i == 6) ? 0 : 1);
      end
    end
    release_tail("t4", 3, 2, 1'b0);

    // Gate already high on WAIT_GATE entry; counter saturates at 3.
    gate = 1'b1;
    trigger("t5a");
    finish_from_wait("t5a", 2, 3, 1'b0);
    trigger("t5b");
    finish_from_wait("t5b", 2, 3, 1'b0);
    trigger("t5c");
    finish_from_wait("t5c", 2, 3, 1'b0);
    // clear_i on the RELEASE->IDLE increment: clear wins.
    trigger("t5d");
    finish_from_wait("t5d", 2, 0, 1'b1);
    trigger("t5e");
    finish_from_wait("t5e", 2, 1, 1'b0);

    // Reset in the middle of FLUSH.
    trigger("t6");
    gate = 1'b1;
    step();
    chk("t6_flush_on", flush, 1);
    rst = 1'b1;
    step();
    chk("t6_rst_err", err, 0);
    chk("t6_rst_flush", flush, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_timeout", tmo, 0);
    chk("t6_rst_count", cnt, 0);
    rst = 1'b0; gate = 1'b0; fifo_empty = 1'b0;
    step();
    chk("t6_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
